// File: rtl/ttl_74166.sv
// SN74LS166-style 8-bit parallel-in serial-out shift register; QH is stage H.
// Define TTL_74166_DELAYS_EN to add REGDLY/MRDLY intra-assignment output delays.
`ifdef TTL_74166_DELAYS_EN
`timescale 1ns/10ps
`endif

module ttl_74166 #(
  parameter int REGDLY = 21,
  parameter int MRDLY  = 23
) (
  input  logic clk,
  input  logic MR,
  input  logic SH_LDn,
  input  logic CLK_INH,
  input  logic SER,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic H,
  output logic QH
);

  // Bit 0 is stage A (serial entry), bit 7 is stage H (serial exit).
  logic [7:0] stage_q, stage_d;
  logic       qh_q, qh_d;

  if (REGDLY < 0 || MRDLY < 0) begin : g_bad_delay
    $error("ttl_74166: delays must be non-negative");
  end

  always_comb begin
    stage_d = stage_q;
    if (!SH_LDn) begin
      stage_d = {H, G, F, E, D, C, B, A};
    end else begin
      stage_d = {stage_q[6:0], SER};
    end
    // On shift this is the old stage G; on load it is pin H.
    qh_d = stage_d[7];
  end

`ifdef TTL_74166_DELAYS_EN
  always_ff @(posedge clk) begin
    if (MR) begin
      stage_q <= #MRDLY '0;
      qh_q    <= #MRDLY 1'b0;
    end else if (!CLK_INH) begin
      stage_q <= #REGDLY stage_d;
      qh_q    <= #REGDLY qh_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (MR) begin
      stage_q <= '0;
      qh_q    <= 1'b0;
    end else if (!CLK_INH) begin
      stage_q <= stage_d;
      qh_q    <= qh_d;
    end
  end
`endif

  assign QH = qh_q;

endmodule

// File: tb/tb_ttl_74166.sv
// Bench for ttl_74166: directed vector table, 74164 loopback, and random run
// against a queue-based model of the shift register.
`ifdef TTL_74166_DELAYS_EN
`timescale 1ns/10ps
`endif

module tb_ttl_74166;

  logic clk = 1'b0;
  logic MR = 1'b0, SH_LDn = 1'b1, CLK_INH = 1'b0, SER = 1'b0;
  logic [7:0] pins = '0;
  logic QH;

  always #20 clk = ~clk;

  ttl_74166 #(.REGDLY(21), .MRDLY(23)) dut (
    .clk(clk), .MR(MR), .SH_LDn(SH_LDn), .CLK_INH(CLK_INH), .SER(SER),
    .A(pins[0]), .B(pins[1]), .C(pins[2]), .D(pins[3]),
    .E(pins[4]), .F(pins[5]), .G(pins[6]), .H(pins[7]),
    .QH(QH)
  );

  // Receive end: 74164 with A=QH, B=1, MRn=1, shifting Q0 toward Q7.
  logic [7:0] rx164 = '0;
  always @(posedge clk) rx164 <= {rx164[6:0], QH & 1'b1};

  int vectors = 0;
  int errors  = 0;

  // Model: queue front is the bit currently presented on QH (stage H).
  bit model_q[$];
  bit model_qh;

  typedef struct {
    bit       mr;
    bit       inh;
    bit       sh;
    bit       ser;
    bit [7:0] pins;
    bit       exp_qh;
    string    name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: QH=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(bit mr, bit inh, bit sh, bit ser, bit [7:0] p);
    if (mr) begin
      model_q = {};
      for (int i = 0; i < 8; i++) model_q.push_back(1'b0);
    end else if (!inh) begin
      if (!sh) begin
        model_q = {};
        for (int i = 7; i >= 0; i--) model_q.push_back(p[i]);
      end else begin
        void'(model_q.pop_front());
        model_q.push_back(ser);
      end
    end
    model_qh = model_q[0];
  endfunction

  // Drive inputs, take one edge, and leave time for QH to settle.
  task automatic step(input bit mr, input bit inh, input bit sh, input bit ser,
                      input bit [7:0] p);
    bit prev;
    prev = model_qh;
    MR = mr; CLK_INH = inh; SH_LDn = sh; SER = ser; pins = p;
    @(posedge clk);
    model_edge(mr, inh, sh, ser, p);
`ifdef TTL_74166_DELAYS_EN
    #20;
    if (model_q.size() == 8 && vectors > 0) check("pre_delay_hold", QH, prev);
    #10;
`else
    #30;
`endif
  endtask

  function automatic void add(bit mr, bit inh, bit sh, bit ser, bit [7:0] p,
                              bit e, string n);
    vec_t v;
    v.mr = mr; v.inh = inh; v.sh = sh; v.ser = ser; v.pins = p;
    v.exp_qh = e; v.name = n;
    tbl.push_back(v);
  endfunction

  initial begin
    bit [7:0] pat;
    bit       r_mr, r_inh, r_sh, r_ser;
    model_qh = 1'b0;

    add(1, 0, 0, 0, 8'hFF, 0, "reset");
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 8'hFF, 0, "reset_shift");
    pat = 8'hB2;
    add(0, 0, 0, 0, pat, pat[7], "load_B2");
    for (int i = 6; i >= 0; i--) add(0, 0, 1, 0, 8'h00, pat[i], "shift_B2");
    add(0, 0, 0, 0, 8'h80, 1, "load_80");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 8'h00, 1, "inhibit_hold");
    add(0, 0, 1, 0, 8'h00, 0, "inhibit_release");
    add(0, 0, 0, 0, 8'h00, 0, "load_00");
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 1, 8'h00, i == 8, "serial_fill");
    add(0, 0, 0, 0, 8'hFF, 1, "load_FF");
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 8'h00, 1, "shift_FF");
    add(1, 0, 1, 1, 8'hFF, 0, "reset_mid_shift");
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 8'hFF, 0, "post_reset_shift");
    add(0, 0, 0, 0, 8'hFF, 1, "load_FF_2");
    add(1, 1, 0, 1, 8'hFF, 0, "reset_over_inhibit");

    @(negedge clk);
    foreach (tbl[k]) begin
      step(tbl[k].mr, tbl[k].inh, tbl[k].sh, tbl[k].ser, tbl[k].pins);
      check(tbl[k].name, QH, tbl[k].exp_qh);
    end

    // Loopback into the 74164 receiver.
    step(0, 0, 0, 0, 8'h5C);
    check("loop_load", QH, model_qh);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 8'h00);
      check("loop_shift", QH, model_qh);
    end
    vectors++;
    if (rx164 !== 8'h5C) begin
      errors++;
      $display("FAIL loopback_74164: Q7..Q0=%h expected 5c", rx164);
    end

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      r_mr  = ($urandom_range(15) == 0);
      r_inh = ($urandom_range(3) == 0);
      r_sh  = ($urandom_range(3) != 0);
      r_ser = $urandom_range(1);
      step(r_mr, r_inh, r_sh, r_ser, 8'($urandom));
      check("random", QH, model_qh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
